// File: rtl/int_controller.sv
// rtl/int_controller.sv - single-level interrupt controller with edge-detected, masked, fixed-priority sources
module int_controller #(
    parameter int          NUM_SRC    = 8,
    parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
    parameter int          VEC_STRIDE = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] irq_in,
    input  logic               mask_we,
    input  logic [NUM_SRC-1:0] mask_din,
    input  logic               int_ack,
    input  logic               int_done,
    output logic               int_out,
    output logic [31:0]        vector_out,
    output logic [3:0]         active_id,
    output logic [NUM_SRC-1:0] pending_out,
    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        SERVICE
    } state_t;

    state_t             state;
    state_t             stateNext;
    logic [NUM_SRC-1:0] irqQ;
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] mask;
    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] eligible;
    logic [NUM_SRC-1:0] clrMask;
    logic [3:0]         selId;
    logic               selValid;
    logic               takeAck;
    logic               intOutNext;
    logic               busyNext;
    logic [31:0]        vecNext;

    assign rise        = irq_in & ~irqQ;
    assign eligible    = pending & mask;
    assign pending_out = pending;

    // Scan downward so the lowest set index wins.
    always_comb begin
        selId    = '0;
        selValid = 1'b0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                selId    = 4'(i);
                selValid = 1'b1;
            end
        end
    end

    always_comb begin
        stateNext  = state;
        intOutNext = int_out;
        busyNext   = busy;
        takeAck    = 1'b0;
        case (state)
            IDLE: begin
                if (selValid) begin
                    stateNext  = REQ;
                    intOutNext = 1'b1;
                end
            end
            REQ: begin
                // Selection is re-evaluated here, so a late higher-priority arrival wins.
                if (int_ack && selValid) begin
                    takeAck    = 1'b1;
                    stateNext  = SERVICE;
                    intOutNext = 1'b0;
                    busyNext   = 1'b1;
                end else if (!selValid) begin
                    stateNext  = IDLE;
                    intOutNext = 1'b0;
                end
            end
            SERVICE: begin
                intOutNext = 1'b0;
                if (int_done) begin
                    stateNext = IDLE;
                    busyNext  = 1'b0;
                end
            end
            default: begin
                stateNext  = IDLE;
                intOutNext = 1'b0;
                busyNext   = 1'b0;
            end
        endcase
    end

    always_comb begin
        clrMask = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            clrMask[i] = takeAck && (selId == 4'(i));
        end
    end

    assign vecNext = VEC_BASE + 32'(selId) * 32'(VEC_STRIDE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            irqQ       <= '0;
            pending    <= '0;
            mask       <= '0;
            int_out    <= 1'b0;
            busy       <= 1'b0;
            vector_out <= '0;
            active_id  <= '0;
        end else begin
            state   <= stateNext;
            irqQ    <= irq_in;
            // A rise in the same cycle as its clear keeps the bit set.
            pending <= (pending & ~clrMask) | rise;
            int_out <= intOutNext;
            busy    <= busyNext;
            if (mask_we) begin
                mask <= mask_din;
            end
            if (takeAck) begin
                vector_out <= vecNext;
                active_id  <= selId;
            end
        end
    end

endmodule

// File: doc/int_controller.md
Name: int_controller

Overview:
Interrupt controller that drives the processor's INT input and serves as the source side of the interrupt handshake. It edge-detects up to NUM_SRC peripheral request lines, latches them as pending, applies a mask, and selects the highest-priority unmasked source. It then raises int_out and holds it until the processor acknowledges, presents the service vector, and blocks further requests until the processor signals end-of-interrupt. There is no nesting: exactly one interrupt is in service at a time.

Parameters:
NUM_SRC, 8, number of request lines (1..16)
VEC_BASE, 32'h0000_0100, vector address of source 0
VEC_STRIDE, 4, byte spacing between consecutive source vectors

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-high
irq_in  input  NUM_SRC  peripheral request lines, sampled each clk
mask_we  input  1  write strobe for mask register
mask_din  input  NUM_SRC  new mask value (1 = enabled)
int_ack  input  1  one-cycle pulse from processor: interrupt accepted
int_done  input  1  one-cycle pulse from processor: return-from-interrupt executed
int_out  output  1  interrupt request to processor INT
vector_out  output  32  service address of the active source
active_id  output  4  index of the source in service
pending_out  output  NUM_SRC  pending register, for debug/status
busy  output  1  high while an interrupt is in service

Behaviour:
- Reset: asynchronous, active-high. Clears irq_q, pending, mask (all disabled), state=IDLE, int_out=0, vector_out=0, active_id=0, busy=0. Reset asserted mid-request or mid-service aborts it, with no residual pending bits.
- Edge detect: irq_q <= irq_in every clk. rise = irq_in & ~irq_q. pending <= (pending & ~clr) | rise. A rise on the same cycle as a clear of that bit leaves the bit set (new event wins).
- Mask: on mask_we, mask <= mask_din at the clk edge. The mask does not clear pending bits. Masked pending bits are held and become eligible as soon as they are unmasked.
- Eligible set = pending & mask. Selected = lowest index set (bit 0 has highest priority).
- FSM, all outputs registered:
  - IDLE: if eligible != 0, go to REQ and set int_out=1.
  - REQ: int_out stays 1.
    - If int_ack: latch active_id=selected, vector_out = VEC_BASE + selected*VEC_STRIDE, clear pending[selected], set int_out=0 and busy=1, go to SERVICE. Selection is evaluated in the ack cycle, so a higher-priority arrival before ack preempts the choice.
    - Else if eligible == 0 (source masked away): int_out=0, go to IDLE.
  - SERVICE: new edges still latch into pending, and int_out stays 0.
    - On int_done: busy=0, go to IDLE. The next eligible source raises int_out one cycle later.
- int_ack outside REQ and int_done outside SERVICE are ignored.
- Latency: irq_in rises and is high at clk edge k, so pending is set at edge k and int_out=1 after edge k+1. Ack at edge a gives vector_out/active_id valid after edge a.
- A held-high irq_in generates only one event. It must fall and rise again to re-pend.
- vector_out and active_id hold their last values after int_done until the next ack.

Test Plan:
- Reset, mask=8'hFF, irq_in[3] rises: pending=8'h08 after 1 clk, int_out=1 after 2 clks. Pulse int_ack: vector_out=32'h10C, active_id=3, pending=0, busy=1, int_out=0.
- irq_in[5] and irq_in[2] rise together, ack: active_id=2, vector=32'h108, pending=8'h20. Pulse int_done: int_out reasserts next cycle, and the next ack gives active_id=5.
- mask=8'h00, irq_in[1] rises: pending=8'h02, int_out stays 0. Write mask=8'h02: int_out=1 two cycles later.
- In REQ for source 4, write mask=8'h00 before ack: int_out drops, FSM returns to IDLE, pending[4] is retained.
- In SERVICE, pulse int_ack and irq_in[0] rises: the ack is ignored, pending=8'h01, and int_out stays 0 until int_done.
- Assert rst while in SERVICE with pending=8'h30: all outputs become 0 immediately (asynchronously), and after release there is no int_out without new edges.
